// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - select/settle/sample scan controller for an 8:1 bit mux
//
// Steps the mux select through every channel enabled in the captured mask,
// in ascending order. Each channel is sampled SETTLE edges after sel takes
// its value. The samples are packed into one word, which is offered on a
// valid/ready handshake.
//
// Optional feature: define SCAN_PARITY_EN to add the data_par output, which
// carries the even parity of data.
//
// Parameters:
//   SETTLE      cycles from a sel update to its sample edge (legal 1..15)
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   scan request, accepted only while idle
//   mask        in   [7:0] channel enables, captured when start is accepted
//   mux_o       in   mux output for the current sel
//   sel         out  [2:0] registered mux select
//   busy        out  high from start acceptance until the word handshake
//   data        out  [7:0] captured word, 0 for disabled channels
//   data_valid  out  word available
//   data_ready  in   consumer accepts word
//   data_par    out  even parity of data (SCAN_PARITY_EN only)

module mux_scan_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       mux_o,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready
`ifdef SCAN_PARITY_EN
    ,
    output logic       data_par
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Reload value: the sample lands SETTLE edges after sel changes.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [7:0] pending_q, pending_d;
    logic [3:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic [7:0] remaining;

    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        data_d    = data_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        remaining = pending_q & ~(8'b1 << sel_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pending_d = mask;
                    data_d    = 8'h00;
                    busy_d    = 1'b1;
                    if (mask != 8'h00) begin
                        sel_d   = lowest_index(mask);
                        cnt_d   = CNT_INIT;
                        state_d = ST_SETTLE;
                    end else begin
                        // Empty scan: HOLD raises valid one edge later.
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d[sel_q] = mux_o;
                    pending_d     = remaining;
                    if (remaining != 8'h00) begin
                        sel_d = lowest_index(remaining);
                        cnt_d = CNT_INIT;
                    end else begin
                        valid_d = 1'b1;
                        par_d   = ^data_d;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (!valid_q) begin
                    // Only reached from the empty-mask path.
                    valid_d = 1'b1;
                    par_d   = ^data_q;
                end else if (data_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            pending_q <= 8'h00;
            cnt_q     <= 4'd0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_valid = valid_q;

`ifdef SCAN_PARITY_EN
    assign data_par = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule
